pipeline_hazard_ctrl: RTL and testbench

//  Hazard/stall sequencer for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB).

---
 rtl/pipeline_hazard_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall sequencer for a 5-stage MIPS pipeline: enables, flushes, forwarding, memory freeze/halt.
// Optional build macro FORWARDING_EN enables EX-stage forwarding; without it RAW hazards stall instead.
module pipeline_hazard_ctrl #(
    parameter int REG_AW      = 5,
    parameter int MEM_TIMEOUT = 8,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic              id_jump,
    input  logic [REG_AW-1:0] ex_rs,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_regwrite,
    input  logic              ex_memread,
    input  logic              ex_br_taken,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_regwrite,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_regwrite,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              pc_we,
    output logic              ifid_we,
    output logic              idex_we,
    output logic              exmem_we,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              memwb_flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_count,
    output logic              mem_err,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_INIT     = 2'd0,
        S_RUN      = 2'd1,
        S_MEM_WAIT = 2'd2,
        S_HALT     = 2'd3
    } state_t;

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d, wait_inc;
    logic [CNT_W-1:0]   stall_q, stall_d;
    logic               mem_err_q, mem_err_d;

    logic freeze, stall_hazard;
    logic ex_src_hit, mem_src_hit;
    logic [1:0] fwd_a_raw, fwd_b_raw;

    // A write to $0 is discarded, so it can never feed a later reader.
    assign ex_src_hit  = (ex_rd != '0) && ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
    assign mem_src_hit = (mem_rd != '0) && ((mem_rd == id_rs) || (id_uses_rt && (mem_rd == id_rt)));

`ifdef FORWARDING_EN
    assign stall_hazard = ex_memread && ex_src_hit;

    always_comb begin
        fwd_a_raw = 2'b00;
        fwd_b_raw = 2'b00;
        if (mem_regwrite && (mem_rd != '0) && (mem_rd == ex_rs))
            fwd_a_raw = 2'b10;
        else if (wb_regwrite && (wb_rd != '0) && (wb_rd == ex_rs))
            fwd_a_raw = 2'b01;
        if (mem_regwrite && (mem_rd != '0) && (mem_rd == ex_rt))
            fwd_b_raw = 2'b10;
        else if (wb_regwrite && (wb_rd != '0) && (wb_rd == ex_rt))
            fwd_b_raw = 2'b01;
    end
`else
    // No bypass network: any pending EX/MEM write to an ID source must drain first.
    assign stall_hazard = ((ex_memread || ex_regwrite) && ex_src_hit) || (mem_regwrite && mem_src_hit);
    assign fwd_a_raw    = 2'b00;
    assign fwd_b_raw    = 2'b00;

    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{ex_rs, ex_rt, wb_rd, wb_regwrite};
`endif

    assign freeze   = mem_req && !mem_ready;
    assign wait_inc = wait_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        stall_d     = stall_q;
        mem_err_d   = mem_err_q;
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        idex_we     = 1'b0;
        exmem_we    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        memwb_flush = 1'b0;
        fwd_a       = fwd_a_raw;
        fwd_b       = fwd_b_raw;

        case (state_q)
            S_INIT: begin
                ifid_we     = 1'b1;
                idex_we     = 1'b1;
                exmem_we    = 1'b1;
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                memwb_flush = 1'b1;
                state_d     = S_RUN;
            end
            S_RUN, S_MEM_WAIT: begin
                if (freeze) begin
                    memwb_flush = 1'b1;
                    wait_d      = wait_inc;
                    if (wait_inc == WAIT_W'(MEM_TIMEOUT)) begin
                        state_d   = S_HALT;
                        mem_err_d = 1'b1;
                    end else begin
                        state_d = S_MEM_WAIT;
                    end
                end else begin
                    state_d  = S_RUN;
                    wait_d   = '0;
                    pc_we    = 1'b1;
                    ifid_we  = 1'b1;
                    idex_we  = 1'b1;
                    exmem_we = 1'b1;
                    if (ex_br_taken) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (stall_hazard) begin
                        // IF/ID holds, so a stalled jump is simply seen again next cycle.
                        pc_we      = 1'b0;
                        ifid_we    = 1'b0;
                        idex_flush = 1'b1;
                    end else if (id_jump) begin
                        ifid_flush = 1'b1;
                    end
                end
                if (!pc_we && (stall_q != '1))
                    stall_d = stall_q + 1'b1;
            end
            default: ;
        endcase

        if (reset) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_we     = 1'b0;
            exmem_we    = 1'b0;
            ifid_flush  = 1'b0;
            idex_flush  = 1'b0;
            memwb_flush = 1'b0;
            fwd_a       = 2'b00;
            fwd_b       = 2'b00;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_INIT;
            wait_q    <= '0;
            stall_q   <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            stall_q   <= stall_d;
            mem_err_q <= mem_err_d;
        end
    end

    assign stall_count = stall_q;
    assign mem_err     = mem_err_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: vector table, directed multi-cycle sequences, randomized run vs model.
module tb_pipeline_hazard_ctrl;

    localparam int AW      = 5;
    localparam int TIMEOUT = 8;
    localparam int CW      = 16;

    typedef struct packed {
        logic [AW-1:0] id_rs, id_rt;
        logic          id_uses_rt, id_jump;
        logic [AW-1:0] ex_rs, ex_rt, ex_rd;
        logic          ex_regwrite, ex_memread, ex_br_taken;
        logic [AW-1:0] mem_rd;
        logic          mem_regwrite;
        logic [AW-1:0] wb_rd;
        logic          wb_regwrite, mem_req, mem_ready;
    } in_t;

    // pc, ifid, idex, exmem write enables; ifid, idex, memwb flushes; fwd_a; fwd_b
    typedef struct packed {
        logic       pc_we, ifid_we, idex_we, exmem_we;
        logic       ifid_flush, idex_flush, memwb_flush;
        logic [1:0] fwd_a, fwd_b;
    } out_t;

    typedef struct packed {
        in_t  in;
        out_t exp;
    } vec_t;

    localparam out_t O_NORM = 11'b1111_000_00_00;
    localparam out_t O_BR   = 11'b1111_110_00_00;
    localparam out_t O_LU   = 11'b0011_010_00_00;
    localparam out_t O_JMP  = 11'b1111_100_00_00;
    localparam out_t O_FZ   = 11'b0000_001_00_00;
    localparam out_t O_INIT = 11'b0111_111_00_00;
    localparam out_t O_ZERO = 11'b0000_000_00_00;

    logic clk = 1'b0;
    logic reset = 1'b1;
    in_t  drv = '0;
    logic pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_flush, memwb_flush, mem_err;
    logic [1:0] fwd_a, fwd_b, dbg_state;
    logic [CW-1:0] stall_count;
    out_t act;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: 0 reset, 1 init cycle, 2 running, 3 halted
    int m_phase = 0;
    int m_wait  = 0;
    int m_stall = 0;
    bit m_err   = 1'b0;

    vec_t vecs[$];

    pipeline_hazard_ctrl #(.REG_AW(AW), .MEM_TIMEOUT(TIMEOUT), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .id_rs(drv.id_rs), .id_rt(drv.id_rt), .id_uses_rt(drv.id_uses_rt), .id_jump(drv.id_jump),
        .ex_rs(drv.ex_rs), .ex_rt(drv.ex_rt), .ex_rd(drv.ex_rd),
        .ex_regwrite(drv.ex_regwrite), .ex_memread(drv.ex_memread), .ex_br_taken(drv.ex_br_taken),
        .mem_rd(drv.mem_rd), .mem_regwrite(drv.mem_regwrite),
        .wb_rd(drv.wb_rd), .wb_regwrite(drv.wb_regwrite),
        .mem_req(drv.mem_req), .mem_ready(drv.mem_ready),
        .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we), .exmem_we(exmem_we),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .memwb_flush(memwb_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_count(stall_count), .mem_err(mem_err),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    assign act = '{pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_flush, memwb_flush, fwd_a, fwd_b};

    function automatic bit id_reads(in_t v, logic [AW-1:0] r);
        return (r != 0) && ((v.id_rs == r) || (v.id_uses_rt && (v.id_rt == r)));
    endfunction

    function automatic logic [1:0] fwd_for(in_t v, logic [AW-1:0] src);
`ifdef FORWARDING_EN
        if (src == 0) return 2'b00;
        if (v.mem_regwrite && v.mem_rd == src) return 2'b10;
        if (v.wb_regwrite && v.wb_rd == src) return 2'b01;
`endif
        return 2'b00;
    endfunction

    function automatic bit must_stall(in_t v);
`ifdef FORWARDING_EN
        return v.ex_memread && id_reads(v, v.ex_rd);
`else
        return ((v.ex_memread || v.ex_regwrite) && id_reads(v, v.ex_rd)) ||
               (v.mem_regwrite && id_reads(v, v.mem_rd));
`endif
    endfunction

    function automatic out_t model_out(in_t v);
        out_t o = O_ZERO;
        if (m_phase == 0) return o;
        o.fwd_a = fwd_for(v, v.ex_rs);
        o.fwd_b = fwd_for(v, v.ex_rt);
        if (m_phase == 1) begin
            o.pc_we = 0; o.ifid_we = 1; o.idex_we = 1; o.exmem_we = 1;
            o.ifid_flush = 1; o.idex_flush = 1; o.memwb_flush = 1;
        end else if (m_phase == 2) begin
            if (v.mem_req && !v.mem_ready) begin
                o.memwb_flush = 1;
            end else begin
                {o.pc_we, o.ifid_we, o.idex_we, o.exmem_we} = 4'b1111;
                if (v.ex_br_taken) begin
                    o.ifid_flush = 1; o.idex_flush = 1;
                end else if (must_stall(v)) begin
                    o.pc_we = 0; o.ifid_we = 0; o.idex_flush = 1;
                end else if (v.id_jump) begin
                    o.ifid_flush = 1;
                end
            end
        end
        return o;
    endfunction

    task automatic model_step(in_t v);
        out_t o = model_out(v);
        if (m_phase == 1) begin
            m_phase = 2;
        end else if (m_phase == 2) begin
            if (!o.pc_we && m_stall < (1 << CW) - 1) m_stall++;
            if (v.mem_req && !v.mem_ready) begin
                m_wait++;
                if (m_wait >= TIMEOUT) begin m_phase = 3; m_err = 1; end
            end else begin
                m_wait = 0;
            end
        end
    endtask

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_model(string name, in_t v);
        chk({name, " outs"}, 32'(act), 32'(model_out(v)));
        chk({name, " stall_count"}, 32'(stall_count), 32'(m_stall));
        chk({name, " mem_err"}, 32'(mem_err), 32'(m_err));
    endtask

    // Apply v after the edge, check at the falling edge, advance the model.
    task automatic cycle(in_t v, string name);
        @(posedge clk); #1;
        drv = v;
        @(negedge clk);
        check_model(name, v);
        model_step(v);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1; drv = '0;
        m_phase = 0; m_wait = 0; m_stall = 0; m_err = 0;
        @(negedge clk);
        chk("reset outs", 32'(act), 32'(O_ZERO));
        chk("reset stall_count", 32'(stall_count), 0);
        chk("reset mem_err", 32'(mem_err), 0);
        @(posedge clk); #1;
        reset = 0; m_phase = 1;
        @(negedge clk);
        chk("init outs", 32'(act), 32'(O_INIT));
        check_model("init", drv);
        model_step(drv);
    endtask

    task automatic add_vec(in_t v, out_t e);
        vec_t x;
        x.in = v; x.exp = e;
        vecs.push_back(x);
    endtask

    initial begin
        in_t z, t, lu;
        out_t e;
        z = '0;

        // Vector table (all in RUN with no memory access)
        add_vec(z, O_NORM);
        t = z; t.ex_br_taken = 1; add_vec(t, O_BR);
        lu = z; lu.ex_memread = 1; lu.ex_regwrite = 1; lu.ex_rd = 2; lu.id_rs = 2; lu.id_rt = 4; lu.id_uses_rt = 1;
        add_vec(lu, O_LU);
        t = z; t.ex_memread = 1; t.ex_regwrite = 1; t.ex_rd = 2; t.id_rs = 7; t.id_rt = 2; add_vec(t, O_NORM);
        t.id_uses_rt = 1; add_vec(t, O_LU);
        t = z; t.ex_memread = 1; t.ex_regwrite = 1; t.ex_rd = 0; add_vec(t, O_NORM);
        t = z; t.id_jump = 1; add_vec(t, O_JMP);
        t = lu; t.id_jump = 1; add_vec(t, O_LU);
        t = lu; t.ex_br_taken = 1; add_vec(t, O_BR);
        t = z; t.mem_regwrite = 1; t.mem_rd = 5; t.wb_regwrite = 1; t.wb_rd = 5; t.ex_rs = 5;
        e = O_NORM;
`ifdef FORWARDING_EN
        e.fwd_a = 2'b10;
`endif
        add_vec(t, e);
        t = z; t.wb_regwrite = 1; t.wb_rd = 6; t.ex_rt = 6;
        e = O_NORM;
`ifdef FORWARDING_EN
        e.fwd_b = 2'b01;
`endif
        add_vec(t, e);
        t = z; t.mem_regwrite = 1; t.wb_regwrite = 1; add_vec(t, O_NORM);
        t = z; t.ex_regwrite = 1; t.ex_rd = 3; t.id_rs = 3;
`ifdef FORWARDING_EN
        add_vec(t, O_NORM);
`else
        add_vec(t, O_LU);
`endif
        t = z; t.mem_regwrite = 1; t.mem_rd = 1; t.id_rs = 1;
`ifdef FORWARDING_EN
        add_vec(t, O_NORM);
`else
        add_vec(t, O_LU);
`endif

        do_reset();
        cycle(z, "run idle");
        chk("run idle explicit", 32'(act), 32'(O_NORM));
        foreach (vecs[i]) begin
            cycle(vecs[i].in, $sformatf("table[%0d]", i));
            chk($sformatf("table[%0d] explicit", i), 32'(act), 32'(vecs[i].exp));
        end

        // Load-use: one stall, counted, then forwarded from WB.
        do_reset();
        cycle(lu, "lu stall");
        chk("lu stall explicit", 32'(act), 32'(O_LU));
        t = z; t.mem_rd = 2; t.mem_regwrite = 1; t.id_rs = 2; t.id_rt = 4; t.id_uses_rt = 1;
        cycle(t, "lu bubble");
        chk("lu stall_count", 32'(stall_count), 1);
        t = z; t.wb_rd = 2; t.wb_regwrite = 1; t.ex_rs = 2; t.ex_rt = 4;
        cycle(t, "lu fwd");
`ifdef FORWARDING_EN
        chk("lu fwd_a", 32'(fwd_a), 1);
`else
        chk("lu fwd_a", 32'(fwd_a), 0);
`endif

        // Memory busy for 3 cycles, then resume.
        do_reset();
        t = z; t.mem_req = 1; t.mem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            cycle(t, "freeze3");
            chk("freeze3 explicit", 32'(act), 32'(O_FZ));
        end
        t.mem_ready = 1;
        cycle(t, "resume");
        chk("resume explicit", 32'(act), 32'(O_NORM));
        cycle(z, "after resume");
        chk("freeze3 stall_count", 32'(stall_count), 3);

        // Randomized run against the model.
        for (int i = 0; i < 400; i++) begin
            t.id_rs        = AW'($urandom_range(0, 3));
            t.id_rt        = AW'($urandom_range(0, 3));
            t.id_uses_rt   = 1'($urandom_range(0, 1));
            t.id_jump      = ($urandom_range(0, 5) == 0);
            t.ex_rs        = AW'($urandom_range(0, 3));
            t.ex_rt        = AW'($urandom_range(0, 3));
            t.ex_rd        = AW'($urandom_range(0, 3));
            t.ex_regwrite  = 1'($urandom_range(0, 1));
            t.ex_memread   = ($urandom_range(0, 2) == 0);
            t.ex_br_taken  = ($urandom_range(0, 6) == 0);
            t.mem_rd       = AW'($urandom_range(0, 3));
            t.mem_regwrite = 1'($urandom_range(0, 1));
            t.wb_rd        = AW'($urandom_range(0, 3));
            t.wb_regwrite  = 1'($urandom_range(0, 1));
            t.mem_req      = ($urandom_range(0, 3) == 0);
            t.mem_ready    = ($urandom_range(0, 3) != 0);
            cycle(t, $sformatf("rand[%0d]", i));
        end

        // Memory never ready: halt after the timeout, stays halted.
        do_reset();
        t = z; t.mem_req = 1; t.mem_ready = 0;
        for (int i = 0; i < TIMEOUT; i++) begin
            cycle(t, "timeout freeze");
            chk("timeout freeze explicit", 32'(act), 32'(O_FZ));
        end
        chk("pre-halt mem_err", 32'(mem_err), 0);
        t.mem_ready = 1;
        cycle(t, "halt");
        chk("halt outs", 32'(act), 32'(O_ZERO));
        chk("halt mem_err", 32'(mem_err), 1);
        t = z; t.ex_br_taken = 1; t.id_jump = 1;
        cycle(t, "halt hold");
        chk("halt hold outs", 32'(act), 32'(O_ZERO));
        chk("halt stall_count", 32'(stall_count), TIMEOUT);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
